// File: rtl/register_file_if.sv
// Register file bus: two combinational read ports, one write port and a debug read port.
// The register file sits on the slave modport; the datapath drives the master side.
interface register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, dbg_addr,
        input  rd_data_a, rd_data_b, dbg_data
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, dbg_addr,
        output rd_data_a, rd_data_b, dbg_data
    );
endinterface

// File: rtl/register_file.sv
// 2**ADDR_W x DATA_W register file, r0 hardwired to zero, async active-low clear.
// Optional define REGFILE_BYPASS_EN forwards same-cycle write data to read ports A and B.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    register_file_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_fire;
    logic              w_hit_a;
    logic              w_hit_b;

    // An X on wr_addr makes this compare unknown, which the if() below treats as false.
    assign w_wr_fire = bus.wr_en && (bus.wr_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_fire) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign w_hit_a = w_wr_fire && (bus.rd_addr_a == bus.wr_addr);
    assign w_hit_b = w_wr_fire && (bus.rd_addr_b == bus.wr_addr);
`else
    assign w_hit_a = 1'b0;
    assign w_hit_b = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] f_port(
        input logic              run,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              hit,
        input logic [DATA_W-1:0] fwd
    );
        if (!run || addr == '0) begin
            return '0;
        end
        if (hit) begin
            return fwd;
        end
        return stored;
    endfunction

    // Reads are gated by rst_n so a forwarded write cannot leak out during reset.
    assign bus.rd_data_a = f_port(rst_n, bus.rd_addr_a, r_mem[bus.rd_addr_a], w_hit_a, bus.wr_data);
    assign bus.rd_data_b = f_port(rst_n, bus.rd_addr_b, r_mem[bus.rd_addr_b], w_hit_b, bus.wr_data);
    assign bus.dbg_data  = f_port(rst_n, bus.dbg_addr,  r_mem[bus.dbg_addr],  1'b0,    bus.wr_data);

    a_wr_addr_known: assert property (@(posedge clk) disable iff (!rst_n)
        bus.wr_en |-> !$isunknown(bus.wr_addr))
        else $error("register_file: write strobe with unknown wr_addr");
endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected reads, a negedge monitor compares.
`timescale 1ns/1ps
module tb_register_file;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rf_if ();

    register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rf_if.slave)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [DEPTH];

    task automatic check(input string nm, input string port, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h (t=%0t)", nm, port, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check(e.name, "rd_data_a", rf_if.rd_data_a, e.a);
            check(e.name, "rd_data_b", rf_if.rd_data_b, e.b);
            check(e.name, "dbg_data",  rf_if.dbg_data,  e.d);
        end
    end

    // Expected read value given the current model and the write being presented this cycle.
    function automatic logic [31:0] exp_port(input logic [4:0] ra, input bit fwd_ok);
        if (!rst_n || ra == 5'd0) return 32'h0;
        if (fwd_ok && BYP && rf_if.wr_en && rf_if.wr_addr != 5'd0 && rf_if.wr_addr == ra)
            return rf_if.wr_data;
        return model[ra];
    endfunction

    task automatic enter_reset();
        rst_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    task automatic step(input string name, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] dg, input bit chk);
        exp_t e;
        rf_if.wr_en     = we;
        rf_if.wr_addr   = wa;
        rf_if.wr_data   = wd;
        rf_if.rd_addr_a = ra;
        rf_if.rd_addr_b = rb;
        rf_if.dbg_addr  = dg;
        if (chk) begin
            e.name = name;
            e.a    = exp_port(ra, 1'b1);
            e.b    = exp_port(rb, 1'b1);
            e.d    = exp_port(dg, 1'b0);
            sb_q.push_back(e);
        end
        @(posedge clk);
        if (rst_n && we && wa != 5'd0) model[wa] = wd;
        #1;
    endtask

    initial begin
        logic [4:0]  wa;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] wd;
        bit          we;

        rf_if.wr_en = 1'b0; rf_if.wr_addr = '0; rf_if.wr_data = '0;
        rf_if.rd_addr_a = '0; rf_if.rd_addr_b = '0; rf_if.dbg_addr = '0;
        enter_reset();
        @(posedge clk); #1;

        step("rst_hold",   1'b0, 5'd0, 32'h0,        5'd5, 5'd31, 5'd7, 1'b1);
        step("rst_wr_ign", 1'b1, 5'd3, 32'h1111_2222, 5'd3, 5'd3,  5'd3, 1'b1);
        rst_n = 1'b1;
        step("post_rst",   1'b0, 5'd0, 32'h0,        5'd3, 5'd3,  5'd3, 1'b1);

        step("r5_same",    1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5, 1'b1);
        step("r5_next",    1'b0, 5'd0, 32'h0,        5'd5, 5'd5,  5'd5, 1'b1);

        step("r0_same",    1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 1'b1);
        step("r0_next",    1'b0, 5'd0, 32'h0,        5'd0, 5'd5,  5'd0, 1'b1);

        step("r31_noen",   1'b0, 5'd31, 32'h1234_5678, 5'd31, 5'd31, 5'd31, 1'b1);
        step("r31_keep",   1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 5'd31, 1'b1);
        step("r31_en",     1'b1, 5'd31, 32'h1234_5678, 5'd31, 5'd0,  5'd31, 1'b1);
        step("r31_read",   1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 5'd31, 1'b1);

        for (int i = 1; i < DEPTH; i++)
            step("fill", 1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'(i), 5'(i - 1), 5'(i), 1'b1);
        for (int i = 0; i < DEPTH; i++)
            step("sweep", 1'b0, 5'd0, 32'h0, 5'(i), 5'(DEPTH - 1 - i), 5'(i), 1'b1);

        // Mid-cycle reset with the file full: contents must vanish before the next edge.
        #2;
        enter_reset();
        step("rst_async",  1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 5'd17, 1'b1);
        rst_n = 1'b1;
        step("rst_clear0", 1'b0, 5'd0, 32'h0, 5'd1, 5'd30, 5'd31, 1'b1);
        step("rst_clear1", 1'b0, 5'd0, 32'h0, 5'd9, 5'd5,  5'd17, 1'b1);

        step("r7_pre",     1'b1, 5'd7, 32'h0BAD_F00D, 5'd7, 5'd7, 5'd7, 1'b1);
        enter_reset();
        step("r7_rst_wr",  1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7, 5'd7, 1'b1);
        rst_n = 1'b1;
        step("r7_after",   1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 5'd7, 1'b1);

        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, DEPTH - 1));
            wd = $urandom;
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, DEPTH - 1));
            rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, DEPTH - 1));
            step("rand", we, wa, wd, ra, rb, 5'($urandom_range(0, DEPTH - 1)), 1'b1);
        end

        rf_if.wr_en = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
